// File: rtl/req_arbiter8_pkg.sv
// Shared types and constants for the 8-way request arbiter.
package req_arbiter8_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   localparam logic [IDX_W-1:0] IDLE_CODE = 3'b111;
   localparam logic [N_REQ-1:0] IDLE_GNT  = 8'hFF;

   function automatic logic [N_REQ-1:0] onehot_n(input logic [IDX_W-1:0] i);
      return ~(N_REQ'(1) << i);
   endfunction

endpackage

// File: rtl/req_arbiter8_rr_pick8.sv
// Winner search: downward from base-1, wrapping, ending at base.
// Fixed mode uses base 0, which yields plain 7..0 priority.
module rr_pick8
   import req_arbiter8_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             rr,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      logic [IDX_W-1:0] base;
      logic [IDX_W-1:0] cand;
      base  = rr ? ptr : '0;
      cand  = '0;
      valid = 1'b0;
      idx   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = base - IDX_W'(k);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/req_arbiter8.sv
// Registered 8-way arbiter: fixed/round-robin pick, hold timeout,
// one-cycle turnaround gap and EI/EO cascade.
module req_arbiter8
   import req_arbiter8_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             EI,
   input  logic [N_REQ-1:0] REQ_N,
   input  logic             RR,
   output logic [N_REQ-1:0] GNT_N,
   output logic [IDX_W-1:0] A,
   output logic             GS,
   output logic             EO,
   output logic             TIMEOUT
);

   localparam int HC_W =
      (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);
   localparam bit HOLD_EN = (MAX_HOLD != 0);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [HC_W-1:0]  hold_q, hold_d;
   logic             to_d;
   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;
   logic [N_REQ-1:0] gnt_d;
   logic [IDX_W-1:0] a_d;
   logic             gs_d;
   logic             eo_d;

   rr_pick8 u_pick (
      .req   (~REQ_N),
      .ptr   (ptr_q),
      .rr    (RR),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         hold_q  <= '0;
         GNT_N   <= IDLE_GNT;
         A       <= IDLE_CODE;
         GS      <= 1'b1;
         EO      <= 1'b1;
         TIMEOUT <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         GNT_N   <= gnt_d;
         A       <= a_d;
         GS      <= gs_d;
         EO      <= eo_d;
         TIMEOUT <= to_d;
      end
   end

   // The pointer doubles as the current owner while in GRANT.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      to_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!EI && pick_valid) begin
               state_d = GRANT;
               ptr_d   = pick_idx;
               hold_d  = HC_W'(1);
            end
         end
         GRANT: begin
            if (REQ_N[ptr_q]) begin
               state_d = GAP;
            end else if (HOLD_EN && hold_q == HOLD_MAX) begin
               state_d = GAP;
               to_d    = 1'b1;
            end else if (hold_q != '1) begin
               hold_d = hold_q + HC_W'(1);
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt_d = IDLE_GNT;
      a_d   = IDLE_CODE;
      gs_d  = 1'b1;
      if (state_d == GRANT) begin
         gnt_d = onehot_n(ptr_d);
         a_d   = ~ptr_d;
         gs_d  = 1'b0;
      end
      eo_d = ~(!EI && state_q == IDLE && REQ_N == IDLE_GNT);
   end

endmodule

// File: tb/tb_req_arbiter8.sv
// Directed bench for req_arbiter8 with MAX_HOLD=4.
module tb_req_arbiter8;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       EI    = 1'b1;
   logic       RR    = 1'b0;
   logic [7:0] REQ_N = 8'hFF;
   logic [7:0] GNT_N;
   logic [2:0] A;
   logic       GS;
   logic       EO;
   logic       TIMEOUT;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   req_arbiter8 #(.MAX_HOLD(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .EI      (EI),
      .REQ_N   (REQ_N),
      .RR      (RR),
      .GNT_N   (GNT_N),
      .A       (A),
      .GS      (GS),
      .EO      (EO),
      .TIMEOUT (TIMEOUT)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] g,
                      input logic [2:0] a, input logic gs,
                      input logic eo, input logic to);
      logic [13:0] obs;
      logic [13:0] exp;
      obs = {GNT_N, A, GS, EO, TIMEOUT};
      exp = {g, a, gs, eo, to};
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got gnt=%b a=%b gs=%b eo=%b to=%b, want gnt=%b a=%b gs=%b eo=%b to=%b",
                tag, GNT_N, A, GS, EO, TIMEOUT, g, a, gs, eo, to);
      end
   endtask

   initial begin
      int         order [9];
      logic [2:0] w;
      order = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

      // reset
      step();
      step();
      chk("reset", 8'hFF, 3'b111, 1'b1, 1'b1, 1'b0);

      // fixed single request, release, gap, idle EO
      rst_n = 1'b1;
      EI    = 1'b0;
      RR    = 1'b0;
      REQ_N = 8'b1111_1110;
      step();
      chk("fix_single", 8'b1111_1110, 3'b111, 1'b0, 1'b1, 1'b0);
      REQ_N = 8'hFF;
      step();
      chk("rel_gap", 8'hFF, 3'b111, 1'b1, 1'b1, 1'b0);
      step();
      step();
      chk("idle_eo0", 8'hFF, 3'b111, 1'b1, 1'b0, 1'b0);

      // fixed priority and gap sequence
      REQ_N = 8'b0111_1110;
      step();
      chk("fix_prio7", 8'b0111_1111, 3'b000, 1'b0, 1'b1, 1'b0);
      REQ_N = 8'b1111_1110;
      step();
      chk("gap7", 8'hFF, 3'b111, 1'b1, 1'b1, 1'b0);
      step();
      chk("idle7", 8'hFF, 3'b111, 1'b1, 1'b1, 1'b0);
      step();
      chk("next0", 8'b1111_1110, 3'b111, 1'b0, 1'b1, 1'b0);
      REQ_N = 8'hFF;
      step();
      step();

      // round-robin fairness
      RR    = 1'b1;
      REQ_N = 8'h00;
      for (int k = 0; k < 9; k++) begin
         step();
         w = 3'(order[k]);
         chk($sformatf("rr%0d", k), ~(8'd1 << w), ~w, 1'b0, 1'b1, 1'b0);
         REQ_N = 8'd1 << w;
         step();
         REQ_N = 8'h00;
         step();
      end

      // timeout on idx 3
      RR    = 1'b0;
      REQ_N = 8'b1111_0111;
      step();
      chk("to_h1", 8'b1111_0111, 3'b100, 1'b0, 1'b1, 1'b0);
      step();
      chk("to_h2", 8'b1111_0111, 3'b100, 1'b0, 1'b1, 1'b0);
      step();
      chk("to_h3", 8'b1111_0111, 3'b100, 1'b0, 1'b1, 1'b0);
      step();
      chk("to_h4", 8'b1111_0111, 3'b100, 1'b0, 1'b1, 1'b0);
      step();
      chk("to_pulse", 8'hFF, 3'b111, 1'b1, 1'b1, 1'b1);
      step();
      chk("to_idle", 8'hFF, 3'b111, 1'b1, 1'b1, 1'b0);
      step();
      chk("to_regrant", 8'b1111_0111, 3'b100, 1'b0, 1'b1, 1'b0);
      step();
      step();
      step();
      chk("re_h4", 8'b1111_0111, 3'b100, 1'b0, 1'b1, 1'b0);
      REQ_N = 8'hFF;
      step();
      chk("rel_at_max", 8'hFF, 3'b111, 1'b1, 1'b1, 1'b0);
      step();

      // enable chain
      EI    = 1'b1;
      REQ_N = 8'h00;
      step();
      chk("ei_block", 8'hFF, 3'b111, 1'b1, 1'b1, 1'b0);
      EI    = 1'b0;
      REQ_N = 8'b1111_1101;
      step();
      chk("ei_grant1", 8'b1111_1101, 3'b110, 1'b0, 1'b1, 1'b0);
      EI = 1'b1;
      step();
      chk("ei_hold2", 8'b1111_1101, 3'b110, 1'b0, 1'b1, 1'b0);
      step();
      chk("ei_hold3", 8'b1111_1101, 3'b110, 1'b0, 1'b1, 1'b0);
      REQ_N = 8'hFF;
      step();
      chk("ei_rel", 8'hFF, 3'b111, 1'b1, 1'b1, 1'b0);
      step();

      // reset mid-grant, RR restarts at 7
      EI    = 1'b0;
      RR    = 1'b1;
      REQ_N = 8'b1101_1111;
      step();
      chk("g5", 8'b1101_1111, 3'b010, 1'b0, 1'b1, 1'b0);
      rst_n = 1'b0;
      REQ_N = 8'h00;
      step();
      chk("mid_reset", 8'hFF, 3'b111, 1'b1, 1'b1, 1'b0);
      rst_n = 1'b1;
      step();
      chk("post_rst7", 8'b0111_1111, 3'b000, 1'b0, 1'b1, 1'b0);
      REQ_N = 8'b1000_0000;
      step();
      REQ_N = 8'h00;
      step();
      step();
      chk("post_rst6", 8'b1011_1111, 3'b001, 1'b0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/req_arbiter8.md
# req_arbiter8

Registered arbiter that shares one downstream resource among 8 requesters using the team's active-low encoder conventions. Request bit 7 has the highest fixed priority, and the granted index is output as an inverted 3-bit code (index 7 → 000). The block adds a fixed/round-robin mode, grant hold with a maximum-hold timeout, a one-cycle turnaround gap between owners, and an EI/EO enable chain for cascading. It sits between the requester blocks and the shared datapath. It sequences ownership of that datapath.

## Interface
- MAX_HOLD, 16: maximum consecutive GRANT cycles for one owner; 0 disables the timeout.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- EI  in  1  active-low enable; while 1, no new grant is issued
- REQ_N  in  8  active-low requests; bit 7 highest priority in fixed mode
- RR  in  1  mode select: 0 = fixed priority, 1 = round-robin; sampled only at arbitration
- GNT_N  out  8  active-low one-hot grant; 8'hFF when no grant
- A  out  3  inverted code of the owner (idx 7 → 000, idx 0 → 111); 111 when no grant
- GS  out  1  0 while any grant is active
- EO  out  1  0 when EI=0, state is IDLE and REQ_N=8'hFF (cascade to the next arbiter's EI)
- TIMEOUT  out  1  one-cycle high pulse when a grant is revoked by MAX_HOLD

## Operation
- States: IDLE, GRANT, GAP. All outputs are registered.
- Reset (rst_n=0 at an edge): state=IDLE, GNT_N=8'hFF, A=111, GS=1, EO=1, TIMEOUT=0, ptr=0, hold_cnt=0.
- **IDLE**
  - If EI=0 and any REQ_N bit is 0: pick a winner, then go to GRANT.
  - On entry to GRANT: GNT_N has only the winner bit low, A=~idx, GS=0, hold_cnt=1, ptr=idx.
  - Otherwise: stay in IDLE.
- **Fixed mode (RR=0):** the winner is the highest index with REQ_N low.
- **Round-robin mode (RR=1):** search from ptr-1 downward, modulo 8, ending at ptr. After reset (ptr=0) the search order is 7,6,…,0, identical to fixed mode.
- **GRANT**
  - If REQ_N[owner]=1 (released): go to GAP.
  - Else if MAX_HOLD≠0 and hold_cnt==MAX_HOLD: go to GAP, with TIMEOUT=1 for the first GAP cycle.
  - Else: stay in GRANT and increment hold_cnt.
  - Other request bits are ignored while in GRANT.
- **GAP:** exactly one cycle with GNT_N=8'hFF, A=111, GS=1, then go to IDLE.
- EI going to 1 during GRANT does not revoke the current grant. Only new grants are blocked.
- A requester that timed out may win again at the next arbitration.
  - In fixed mode it regains ownership if it is still the highest requester.
  - In round-robin mode it is searched last.
- EO is registered from the current EI, state and REQ_N. EO=1 whenever EI=1.
- hold_cnt width is clog2(MAX_HOLD+1), minimum 1 bit. It saturates and does not wrap.

## Timing
- Request to grant: 1 cycle. A REQ_N bit low at edge N while in IDLE gives GNT_N low after edge N.
- Release to next grant: 3 edges.
  - Release is seen at edge N; GAP is visible after edge N.
  - IDLE is visible after edge N+1.
  - The new grant is visible after edge N+2.
- Grant duration: at most MAX_HOLD cycles with GS=0.
- TIMEOUT is coincident with the first cycle where GNT_N returns to 8'hFF.
- Simultaneous release and timeout at the same edge: treated as a release, so TIMEOUT=0.
- Reset mid-GRANT: all outputs take their reset values after that edge. No GAP cycle is produced.
- Requests asserted during GAP are not granted until IDLE is evaluated on the following edge.

## Structure
- Shared package/include holds:
  - State encodings: IDLE=2'd0, GRANT=2'd1, GAP=2'd2.
  - N_REQ=8 and IDX_W=3.
  - The idle code 3'b111 and the idle grant 8'hFF.
- One combinational sub-module, rr_pick8.
  - Inputs: req (active-high, = ~REQ_N), ptr, rr.
  - Outputs: valid and idx[2:0].
- The top level contains the FSM, hold counter, pointer register and output registers.

## Test plan
1. Fixed-mode single request: reset, EI=0, RR=0, REQ_N=8'b1111_1110 → next cycle GNT_N=8'b1111_1110, A=111, GS=0, EO=1.
2. Fixed priority and gap: REQ_N=8'b0111_1110 → GNT_N=8'b0111_1111, A=000. Then release bit 7 → one cycle GNT_N=8'hFF, then IDLE, then GNT_N=8'b1111_1110, A=111.
3. Round-robin fairness: RR=1, all 8 requesting, each owner releases after 1 cycle and re-requests → grant order 7,6,5,4,3,2,1,0,7.
4. Timeout: MAX_HOLD=4, REQ_N[3] held low alone → GS=0 for exactly 4 cycles, then GNT_N=8'hFF with TIMEOUT=1 for 1 cycle, then regrant of idx 3 (A=100).
5. Enable chain:
   - EI=1 with REQ_N=8'h00 → no grant, EO=1.
   - EI=0, REQ_N=8'hFF, in IDLE → EO=0.
   - EI to 1 mid-GRANT → grant is held until release.
6. Reset mid-grant: rst_n=0 during GRANT of idx 5 → after that edge GNT_N=8'hFF, A=111, GS=1, TIMEOUT=0, and RR order restarts at 7.
